// File: rtl/spi_sram_responder.sv
// rtl/spi_sram_responder.sv - SPI mode-0 slave model of an 8 KB serial SRAM (READ/WRITE/RDSR/WRSR)
module spi_sram_responder #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_cs,
    input  logic              i_si,
    output logic              o_so,
    output logic [7:0]        o_status,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_WDATA  = 3'd4;
    localparam logic [2:0] ST_WRSR   = 3'd5;
    localparam logic [2:0] ST_RDSR   = 3'd6;
    localparam logic [2:0] ST_IGNORE = 3'd7;

    // Shift register only needs to hold the implemented address bits (or one byte)
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

    logic [2:0]        state;
    logic              sck_q;
    logic [3:0]        bit_cnt;
    logic [SH_W-2:0]   shift;
    logic [6:0]        tx;
    logic [ADDR_W-1:0] addr;
    logic              is_write;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    logic              rise;
    logic [SH_W-1:0]   shift_in;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic              byte_mode;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_byte;
    logic              mem_wr;

    assign rise      = i_sck & ~sck_q & ~i_cs;
    assign shift_in  = {shift, i_si};
    assign byte_in   = shift_in[7:0];
    assign byte_done = (bit_cnt[2:0] == 3'd7);
    assign byte_mode = (o_status[7] == o_status[6]);

    always_comb begin
        next_addr = addr;
        case (o_status[7:6])
            2'b01:   next_addr = addr + ADDR_W'(1);
            2'b10:   next_addr[4:0] = addr[4:0] + 5'd1;
            default: next_addr = addr;
        endcase
    end

    // One asynchronous read port serves both the first byte after ADDR and each reload
    assign load_addr = (state == ST_ADDR) ? shift_in[ADDR_W-1:0] : next_addr;
    assign load_byte = mem[load_addr];
    assign mem_wr    = (state == ST_WDATA) & rise & byte_done & ~i_cs;

    always_ff @(posedge i_clk) begin
        if (mem_wr)
            mem[addr] <= byte_in;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            sck_q      <= 1'b0;
            bit_cnt    <= 4'd0;
            shift      <= '0;
            tx         <= 7'd0;
            addr       <= '0;
            is_write   <= 1'b0;
            o_so       <= 1'b0;
            o_status   <= 8'h00;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= 8'h00;
        end else begin
            sck_q      <= i_sck;
            o_wr_valid <= 1'b0;
            if (i_cs) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                o_so    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= 4'd0;
                    end
                    ST_CMD: if (rise) begin
                        shift   <= shift_in[SH_W-2:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            case (byte_in)
                                8'h03: begin state <= ST_ADDR; is_write <= 1'b0; end
                                8'h02: begin state <= ST_ADDR; is_write <= 1'b1; end
                                8'h01: state <= ST_WRSR;
                                8'h05: begin
                                    state <= ST_RDSR;
                                    tx    <= o_status[6:0];
                                    o_so  <= o_status[7];
                                end
                                default: state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: if (rise) begin
                        shift   <= shift_in[SH_W-2:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            addr <= load_addr;
                            if (is_write) begin
                                state <= ST_WDATA;
                            end else begin
                                state <= ST_RDATA;
                                tx    <= load_byte[6:0];
                                o_so  <= load_byte[7];
                            end
                        end
                    end
                    ST_RDATA: if (rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            addr    <= next_addr;
                            if (byte_mode) begin
                                state <= ST_IGNORE;
                                o_so  <= 1'b0;
                            end else begin
                                tx   <= load_byte[6:0];
                                o_so <= load_byte[7];
                            end
                        end else begin
                            tx   <= {tx[5:0], 1'b0};
                            o_so <= tx[6];
                        end
                    end
                    ST_WDATA: if (rise) begin
                        shift   <= shift_in[SH_W-2:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            bit_cnt    <= 4'd0;
                            o_wr_valid <= 1'b1;
                            o_wr_addr  <= addr;
                            o_wr_data  <= byte_in;
                            addr       <= next_addr;
                            if (byte_mode)
                                state <= ST_IGNORE;
                        end
                    end
                    ST_WRSR: if (rise) begin
                        shift   <= shift_in[SH_W-2:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            bit_cnt  <= 4'd0;
                            o_status <= {byte_in[7:6], 5'b0, byte_in[0]};
                            state    <= ST_IGNORE;
                        end
                    end
                    ST_RDSR: if (rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            bit_cnt <= 4'd0;
                            tx      <= o_status[6:0];
                            o_so    <= o_status[7];
                        end else begin
                            tx   <= {tx[5:0], 1'b0};
                            o_so <= tx[6];
                        end
                    end
                    default: o_so <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
// tb/tb_spi_sram_responder.sv - directed bench with byte-level SRAM model and per-cycle output checks
module tb_spi_sram_responder;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sck = 1'b0;
    logic              cs  = 1'b1;
    logic              si  = 1'b0;
    logic              so;
    logic [7:0]        status;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    always #5 clk = ~clk;

    spi_sram_responder #(.ADDR_W(ADDR_W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sck     (sck),
        .i_cs      (cs),
        .i_si      (si),
        .o_so      (so),
        .o_status  (status),
        .o_wr_valid(wr_valid),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mem_m [DEPTH];
    logic [7:0]  status_m = 8'h00;
    logic [20:0] exp_q [$];
    logic [20:0] exp_e;
    int          pulses = 0;
    bit          cmp_en = 1'b0;
    logic [7:0]  txb [8];
    logic [7:0]  rx  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int addr_at(input int a, input int i, input logic [1:0] mode);
        case (mode)
            2'b01:   return (a + i) % DEPTH;
            2'b10:   return (a & ~31) | ((a + i) & 31);
            default: return a;
        endcase
    endfunction

    task automatic load(input logic [7:0] b0, b1, b2, b3, b4, b5);
        txb[0] = b0; txb[1] = b1; txb[2] = b2; txb[3] = b3; txb[4] = b4; txb[5] = b5;
        for (int i = 6; i < 8; i++) txb[i] = 8'h00;
        for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    endtask

    // Drives one CS-low transaction; the model works per completed byte and per data index
    task automatic spi(input int nbits, input bit keep_cs);
        logic [7:0] op;
        int         a;
        logic [1:0] mode;
        bit         bytem;
        logic [7:0] eb;
        int         j, k, ad;
        op    = txb[0];
        a     = {16'd0, txb[1], txb[2]} % DEPTH;
        mode  = status_m[7:6];
        bytem = (mode == 2'b00) || (mode == 2'b11);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < nbits; n++) begin
            j  = n / 8;
            k  = 7 - (n % 8);
            si = txb[j][k];
            eb = 8'h00;
            if (op == 8'h03 && j >= 3)
                eb = (bytem && j > 3) ? 8'h00 : mem_m[addr_at(a, j - 3, mode)];
            else if (op == 8'h05 && j >= 1)
                eb = status_m;
            repeat (2) @(negedge clk);
            chk("so_bit", {31'd0, so}, {31'd0, eb[k]});
            rx[j][k] = so;
            sck = 1'b1;
            if (k == 0) begin
                if (op == 8'h02 && j >= 3 && !(bytem && j > 3)) begin
                    ad = addr_at(a, j - 3, mode);
                    mem_m[ad] = txb[j];
                    exp_q.push_back({ad[ADDR_W-1:0], txb[j]});
                end
                if (op == 8'h01 && j == 1)
                    status_m = {txb[1][7:6], 5'b0, txb[1][0]};
            end
            repeat (2) @(negedge clk);
            sck = 1'b0;
        end
        if (!keep_cs) begin
            repeat (2) @(negedge clk);
            cs = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("status", {24'd0, status}, {24'd0, status_m});
            chk("wr_valid", {31'd0, wr_valid}, {31'd0, exp_q.size() != 0});
            if (wr_valid && exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", {19'd0, wr_addr}, {19'd0, exp_e[20:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, exp_e[7:0]});
            end
            if (wr_valid) pulses++;
        end
    end

    int p0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_so", {31'd0, so}, 32'd0);
        chk("rst_status", {24'd0, status}, 32'h00);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;

        // SCK activity with CS high must be ignored
        p0 = pulses;
        si = 1'b1;
        for (int i = 0; i < 24; i++) begin
            sck = 1'b1; repeat (2) @(negedge clk);
            sck = 1'b0; repeat (2) @(negedge clk);
        end
        chk("cs_high_writes", pulses - p0, 0);

        load(8'h01, 8'h41, 0, 0, 0, 0); spi(16, 0);
        chk("wrsr_41", {24'd0, status}, 32'h41);
        load(8'h05, 0, 0, 0, 0, 0); spi(24, 0);
        chk("rdsr_b1", {24'd0, rx[1]}, 32'h41);
        chk("rdsr_b2", {24'd0, rx[2]}, 32'h41);

        p0 = pulses;
        load(8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A, 0); spi(40, 0);
        chk("seq_writes", pulses - p0, 2);
        load(8'h03, 8'h00, 8'h10, 0, 0, 0); spi(40, 0);
        chk("seq_rd0", {24'd0, rx[3]}, 32'hA5);
        chk("seq_rd1", {24'd0, rx[4]}, 32'h5A);

        load(8'h02, 8'hFF, 8'hFF, 8'h11, 8'h22, 0); spi(40, 0);
        load(8'h03, 8'h1F, 8'hFF, 0, 0, 0); spi(40, 0);
        chk("wrap_rd0", {24'd0, rx[3]}, 32'h11);
        chk("wrap_rd1", {24'd0, rx[4]}, 32'h22);

        load(8'h01, 8'hFF, 0, 0, 0, 0); spi(16, 0);
        chk("wrsr_mask", {24'd0, status}, 32'hC1);

        load(8'h01, 8'h81, 0, 0, 0, 0); spi(16, 0);
        load(8'h02, 8'h00, 8'h3F, 8'h33, 8'h44, 0); spi(40, 0);
        load(8'h03, 8'h00, 8'h3F, 0, 0, 0); spi(40, 0);
        chk("page_rd0", {24'd0, rx[3]}, 32'h33);
        chk("page_rd1", {24'd0, rx[4]}, 32'h44);
        load(8'h01, 8'h40, 0, 0, 0, 0); spi(16, 0);
        load(8'h03, 8'h00, 8'h20, 0, 0, 0); spi(32, 0);
        chk("page_wrap_dest", {24'd0, rx[3]}, 32'h44);

        load(8'h01, 8'h00, 0, 0, 0, 0); spi(16, 0);
        p0 = pulses;
        load(8'h02, 8'h01, 8'h00, 8'h77, 8'h88, 8'h99); spi(48, 0);
        chk("byte_writes", pulses - p0, 1);
        load(8'h03, 8'h01, 8'h00, 0, 0, 0); spi(48, 0);
        chk("byte_rd0", {24'd0, rx[3]}, 32'h77);
        chk("byte_rd1", {24'd0, rx[4]}, 32'h00);
        chk("byte_rd2", {24'd0, rx[5]}, 32'h00);

        p0 = pulses;
        load(8'h02, 8'h01, 8'h00, 8'hEE, 0, 0); spi(28, 0);
        chk("abort_writes", pulses - p0, 0);
        load(8'h03, 8'h01, 8'h00, 0, 0, 0); spi(32, 0);
        chk("abort_rd", {24'd0, rx[3]}, 32'h77);

        p0 = pulses;
        load(8'h9F, 8'h12, 8'h34, 0, 0, 0); spi(24, 0);
        chk("unknown_writes", pulses - p0, 0);

        // Reset in the middle of a data byte
        load(8'h01, 8'h41, 0, 0, 0, 0); spi(16, 0);
        p0 = pulses;
        load(8'h02, 8'h01, 8'h00, 8'h55, 0, 0); spi(29, 1);
        rst = 1'b1;
        status_m = 8'h00;
        repeat (2) @(negedge clk);
        chk("midrst_status", {24'd0, status}, 32'h00);
        cs = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_writes", pulses - p0, 0);
        load(8'h03, 8'h01, 8'h00, 0, 0, 0); spi(32, 0);
        chk("midrst_rd", {24'd0, rx[3]}, 32'h77);

        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
